// File: rtl/smuladd_seq.sv
// smuladd_seq: sequential signed multiply-add, y = q*dvsr + rem.
// It rebuilds a dividend from the results of SDIV/SMOD. It uses a radix-2
// shift-add over DATAWIDTH cycles, so no wide combinational multiplier is needed.
//
// State table
//   state | meaning
//   IDLE  | waiting for start; y/ovf hold the last result
//   CALC  | one partial product per cycle, W cycles
//   FIN   | apply sign, add rem, update y/ovf, pulse done
//
// Ports
//   clk   rising-edge clock
//   rst   asynchronous active-low reset
//   start operation request, honoured only while idle
//   q     signed multiplicand (quotient)
//   dvsr  signed multiplier (divisor)
//   rem   signed addend (remainder)
//   busy  operation in progress
//   done  one-cycle pulse when y/ovf have just been updated
//   y     low W bits of q*dvsr+rem
//   ovf   exact result does not fit in W-bit signed
module smuladd_seq #(
   parameter int DATAWIDTH = 64
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [DATAWIDTH-1:0] q,
   input  logic [DATAWIDTH-1:0] dvsr,
   input  logic [DATAWIDTH-1:0] rem,
   output logic                 busy,
   output logic                 done,
   output logic [DATAWIDTH-1:0] y,
   output logic                 ovf
);

   localparam int W  = DATAWIDTH;
   localparam int CW = $clog2(W);
   localparam int AW = 2 * W;
   localparam int PW = 2 * W + 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CALC = 2'd1;
   localparam logic [1:0] FIN  = 2'd2;

   logic [1:0]    state;
   logic [CW-1:0] cnt;
   logic [AW-1:0] mcand;
   logic [W-1:0]  mplier;
   logic [W-1:0]  rem_r;
   logic [AW-1:0] acc;
   logic          sgn;

   // |-2^(W-1)| wraps to the bit pattern 2^(W-1), which is correct as unsigned.
   logic [W-1:0]  q_mag;
   logic [W-1:0]  dvsr_mag;
   logic [PW-1:0] p_full;
   logic [PW-1:0] r_full;
   logic          r_ovf;

   always_comb begin
      q_mag    = q[W-1]    ? (W'(0) - q)    : q;
      dvsr_mag = dvsr[W-1] ? (W'(0) - dvsr) : dvsr;
      p_full   = sgn ? (PW'(0) - {1'b0, acc}) : {1'b0, acc};
      r_full   = p_full + {{(W + 1){rem_r[W-1]}}, rem_r};
      // Fits in W-bit signed only if bits 2W..W-1 are all copies of the sign.
      r_ovf    = ~(&r_full[PW-1:W-1]) & (|r_full[PW-1:W-1]);
   end

   assign busy = (state != IDLE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         cnt    <= '0;
         mcand  <= '0;
         mplier <= '0;
         rem_r  <= '0;
         acc    <= '0;
         sgn    <= 1'b0;
         done   <= 1'b0;
         y      <= '0;
         ovf    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  mcand  <= {{W{1'b0}}, q_mag};
                  mplier <= dvsr_mag;
                  rem_r  <= rem;
                  sgn    <= q[W-1] ^ dvsr[W-1];
                  acc    <= '0;
                  cnt    <= '0;
                  state  <= CALC;
               end
            end
            CALC: begin
               // mcand is pre-shifted each cycle, so it always equals |q| << cnt.
               if (mplier[0]) begin
                  acc <= acc + mcand;
               end
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               cnt    <= cnt + CW'(1);
               if (cnt == CW'(W - 1)) begin
                  state <= FIN;
               end
            end
            FIN: begin
               y     <= r_full[W-1:0];
               ovf   <= r_ovf;
               done  <= 1'b1;
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_smuladd_seq.sv
// Directed bench for smuladd_seq. It runs one W=64 and one W=8 instance from
// a shared clock and reset. Expected values are computed by hand.
module tb_smuladd_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        st64, st8;
   logic [63:0] q64, d64, r64, y64;
   logic [7:0]  q8, d8, r8, y8;
   logic        busy64, done64, ovf64;
   logic        busy8, done8, ovf8;

   int checks = 0;
   int errors = 0;

   smuladd_seq #(.DATAWIDTH(64)) dut64 (
      .clk(clk), .rst(rst), .start(st64), .q(q64), .dvsr(d64), .rem(r64),
      .busy(busy64), .done(done64), .y(y64), .ovf(ovf64)
   );

   smuladd_seq #(.DATAWIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .start(st8), .q(q8), .dvsr(d8), .rem(r8),
      .busy(busy8), .done(done8), .y(y8), .ovf(ovf8)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          s8;
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] c;
      logic [63:0] ey;
      bit          eo;
   } vec_t;

   vec_t tbl[17];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [63:0] yv(input bit s8);
      return s8 ? {56'b0, y8} : y64;
   endfunction

   function automatic logic ovfv(input bit s8);
      return s8 ? ovf8 : ovf64;
   endfunction

   function automatic logic busyv(input bit s8);
      return s8 ? busy8 : busy64;
   endfunction

   function automatic logic donev(input bit s8);
      return s8 ? done8 : done64;
   endfunction

   // Drive start for one edge. After that edge, scramble the operands so the
   // DUT has to work from its latched copies.
   task automatic launch(input bit s8, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] c);
      if (s8) begin
         q8 = a[7:0]; d8 = b[7:0]; r8 = c[7:0]; st8 = 1'b1;
      end else begin
         q64 = a; d64 = b; r64 = c; st64 = 1'b1;
      end
      @(posedge clk);
      #1;
      st8  = 1'b0;
      st64 = 1'b0;
      q8   = 8'($urandom);
      d8   = 8'($urandom);
      r8   = 8'($urandom);
      q64  = {$urandom, $urandom};
      d64  = {$urandom, $urandom};
      r64  = {$urandom, $urandom};
   endtask

   // Called #1 after the accepting edge. Returns the number of edges until
   // done is seen, the number of busy cycles, and whether y held its value.
   task automatic wait_done(input bit s8, output int n, output int bc, output bit stable);
      logic [63:0] prev;
      int          lim;
      lim    = s8 ? 18 : 74;
      prev   = yv(s8);
      bc     = int'(busyv(s8));
      n      = 0;
      stable = 1'b1;
      while (n < lim) begin
         @(posedge clk);
         #1;
         n++;
         if (donev(s8)) break;
         bc += int'(busyv(s8));
         if (yv(s8) !== prev) stable = 1'b0;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int          n, bc, dc, first, w;
      bit          stable;
      logic [63:0] m, ycap;

      tbl[0]  = '{1'b0, 64'd7, 64'd3, 64'd1, 64'd22, 1'b0};
      tbl[1]  = '{1'b0, -64'sd7, 64'd3, -64'sd1, -64'sd22, 1'b0};
      tbl[2]  = '{1'b0, 64'd0, -64'sd9, -64'sd5, -64'sd5, 1'b0};
      tbl[3]  = '{1'b0, 64'h8000_0000_0000_0000, -64'sd1, 64'd0, 64'h8000_0000_0000_0000, 1'b1};
      tbl[4]  = '{1'b0, 64'h4000_0000_0000_0000, 64'd2, -64'sd1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0};
      tbl[5]  = '{1'b0, 64'h8000_0000_0000_0000, 64'd1, 64'd0, 64'h8000_0000_0000_0000, 1'b0};
      tbl[6]  = '{1'b0, 64'h1_0000_0000, 64'h1_0000_0000, 64'd0, 64'd0, 1'b1};
      tbl[7]  = '{1'b0, 64'd123456789, -64'sd1000, 64'd42, -64'sd123456788958, 1'b0};
      tbl[8]  = '{1'b1, 64'h80, 64'hFF, 64'h00, 64'h80, 1'b1};
      tbl[9]  = '{1'b1, 64'd16, 64'd8, 64'hFF, 64'h7F, 1'b0};
      tbl[10] = '{1'b1, 64'd16, 64'd8, 64'h00, 64'h80, 1'b1};
      tbl[11] = '{1'b1, 64'h7F, 64'h7F, 64'h7F, 64'h80, 1'b1};
      tbl[12] = '{1'b1, 64'h80, 64'h80, 64'h80, 64'h80, 1'b1};
      tbl[13] = '{1'b1, 64'h80, 64'h01, 64'hFF, 64'h7F, 1'b1};
      tbl[14] = '{1'b1, 64'h00, 64'h00, 64'h00, 64'h00, 1'b0};
      tbl[15] = '{1'b1, 64'hFD, 64'h04, 64'h02, 64'hF6, 1'b0};
      tbl[16] = '{1'b1, 64'hFF, 64'hFF, 64'hFF, 64'h00, 1'b0};

      rst = 1'b0; st64 = 1'b0; st8 = 1'b0;
      q64 = '0; d64 = '0; r64 = '0; q8 = '0; d8 = '0; r8 = '0;
      #12;
      chk("reset_busy64", {63'b0, busy64}, 64'd0);
      chk("reset_done64", {63'b0, done64}, 64'd0);
      chk("reset_y64", y64, 64'd0);
      chk("reset_ovf64", {63'b0, ovf64}, 64'd0);
      chk("reset_busy8", {63'b0, busy8}, 64'd0);
      chk("reset_y8", {56'b0, y8}, 64'd0);
      #10 rst = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 17; i++) begin
         w = tbl[i].s8 ? 8 : 64;
         m = tbl[i].s8 ? 64'hFF : 64'hFFFF_FFFF_FFFF_FFFF;
         launch(tbl[i].s8, tbl[i].a, tbl[i].b, tbl[i].c);
         wait_done(tbl[i].s8, n, bc, stable);
         chk($sformatf("latency[%0d]", i), 64'(n), 64'(w + 1));
         chk($sformatf("busy_cycles[%0d]", i), 64'(bc), 64'(w + 1));
         chk($sformatf("y[%0d]", i), yv(tbl[i].s8), tbl[i].ey & m);
         chk($sformatf("ovf[%0d]", i), {63'b0, ovfv(tbl[i].s8)}, {63'b0, tbl[i].eo});
         chk($sformatf("busy_in_done[%0d]", i), {63'b0, busyv(tbl[i].s8)}, 64'd0);
         chk($sformatf("y_held[%0d]", i), {63'b0, stable}, 64'd1);
         @(posedge clk);
         #1;
         chk($sformatf("done_pulse[%0d]", i), {63'b0, donev(tbl[i].s8)}, 64'd0);
      end

      // A start issued while busy is ignored: there is a single done, and it
      // carries the first result.
      launch(1'b1, 64'd5, 64'd5, 64'd0);
      dc = 0; first = -1; ycap = '0;
      for (int e = 1; e <= 30; e++) begin
         if (e == 3) begin
            q8 = 8'hFF; d8 = 8'hFF; r8 = 8'hFF; st8 = 1'b1;
         end
         @(posedge clk);
         #1;
         st8 = 1'b0;
         if (done8) begin
            dc++;
            if (first < 0) begin
               first = e;
               ycap  = {56'b0, y8};
            end
         end
      end
      chk("busy_start_done_count", 64'(dc), 64'd1);
      chk("busy_start_latency", 64'(first), 64'd9);
      chk("busy_start_y", ycap, 64'd25);

      // A start in the done cycle is accepted. The previous y holds until the
      // next done.
      launch(1'b1, 64'd5, 64'd5, 64'd0);
      wait_done(1'b1, n, bc, stable);
      chk("b2b_first_y", yv(1'b1), 64'd25);
      launch(1'b1, 64'hFD, 64'h04, 64'h02);
      wait_done(1'b1, n, bc, stable);
      chk("b2b_latency", 64'(n), 64'd9);
      chk("b2b_y_held", {63'b0, stable}, 64'd1);
      chk("b2b_y", yv(1'b1), 64'hF6);
      chk("b2b_ovf", {63'b0, ovf8}, 64'd0);

      // An asynchronous reset in the middle of CALC aborts the operation.
      launch(1'b0, 64'd7, 64'd3, 64'd1);
      repeat (19) @(posedge clk);
      #3 rst = 1'b0;
      #1;
      chk("abort_busy", {63'b0, busy64}, 64'd0);
      chk("abort_done", {63'b0, done64}, 64'd0);
      chk("abort_y", y64, 64'd0);
      chk("abort_ovf", {63'b0, ovf64}, 64'd0);
      #2 rst = 1'b1;
      dc = 0;
      repeat (80) begin
         @(posedge clk);
         #1;
         if (done64) dc++;
      end
      chk("abort_no_done", 64'(dc), 64'd0);
      launch(1'b0, 64'd7, 64'd3, 64'd1);
      wait_done(1'b0, n, bc, stable);
      chk("post_abort_latency", 64'(n), 64'd65);
      chk("post_abort_y", y64, 64'd22);
      chk("post_abort_ovf", {63'b0, ovf64}, 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
